datapath_ctrl: RTL and testbench

Instruction sequencer that drives every control input of the `datapath` block: register-file read/write selects, A/B/C/status load enables, shifter, operand muxes and ALU op. It latches one 16-bit instruction on a start request, walks a Moore FSM through the register reads, ALU operation and write-back, then raises `w` to accept the next instruction. It sits between instruction source and `datapath`, replacing hand-driven control sequences.

---
 rtl/datapath_ctrl.sv | 162 ++++++++++++++++
 tb/tb_datapath_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// Moore sequencer that drives the datapath control inputs for one latched 16-bit instruction.
// Optional illegal-opcode trap (err port, TRAP state) is enabled by defining DP_CTRL_TRAP_EN.
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  input  logic        Z,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
`ifdef DP_CTRL_TRAP_EN
  output logic [15:0] datapath_in,
  output logic        err
`else
  output logic [15:0] datapath_in
`endif
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
`ifdef DP_CTRL_TRAP_EN
    S_WRITE_REG,
    S_TRAP
`else
    S_WRITE_REG
`endif
  } state_t;

  state_t      state, next_state;
  logic [15:0] ir;

  // Status flag is carried for interface compatibility; the sequence never branches on it.
  logic z_unused;
  assign z_unused = Z;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  assign datapath_in = {{8{ir[7]}}, ir[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_WAIT && s)
        ir <= in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:      if (s) next_state = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)
          next_state = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)
          next_state = S_GET_B;
        else if (is_alu)
          next_state = S_GET_A;
        else
`ifdef DP_CTRL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_WAIT;
`endif
      end
      S_WRITE_IMM: next_state = S_WAIT;
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_ALU;
      S_ALU:       next_state = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: next_state = S_WAIT;
`ifdef DP_CTRL_TRAP_EN
      S_TRAP:      next_state = S_TRAP;
`endif
      default:     next_state = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    vsel     = 1'b0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
`ifdef DP_CTRL_TRAP_EN
    err      = 1'b0;
`endif
    case (state)
      S_WAIT:      w = 1'b1;
      S_WRITE_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = rn;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        // Single-operand forms pass zero through A so the ALU sees only shifted B.
        shift = sh;
        loadc = 1'b1;
        asel  = is_mov_reg || is_mvn;
        loads = is_cmp;
        ALUop = is_alu ? op : 2'b00;
      end
      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = rd;
      end
`ifdef DP_CTRL_TRAP_EN
      S_TRAP:      err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: per-cycle control vectors compared against hand-computed values.
// Builds with or without DP_CTRL_TRAP_EN to match the RTL configuration.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] in = '0;
  logic        Z = 1'b0;
  logic        w, vsel, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;
  logic        err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  datapath_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in), .Z(Z),
    .w(w), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
`ifdef DP_CTRL_TRAP_EN
    .ALUop(ALUop), .datapath_in(datapath_in), .err(err)
`else
    .ALUop(ALUop), .datapath_in(datapath_in)
`endif
  );

`ifndef DP_CTRL_TRAP_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  logic [18:0] ctl;
  assign ctl = {w, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                readnum, writenum, shift, ALUop};

  function automatic logic [18:0] pk(input logic w_, input logic wr, input logic vs,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as_, input logic bs,
                                     input logic [2:0] rn, input logic [2:0] wn,
                                     input logic [1:0] sh, input logic [1:0] alu);
    return {w_, wr, vs, la, lb, lc, ls, as_, bs, rn, wn, sh, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare the current cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [18:0] exp);
    check(tag, {13'd0, ctl}, {13'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic hold);
    @(negedge clk);
    in = ins;
    s  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) s = 1'b0;
  endtask

  localparam logic [18:0] IDLE = 19'h40000;
  localparam logic [18:0] NONE = 19'h00000;

  initial begin
    #2;
    check("reset_ctl", {13'd0, ctl}, {13'd0, IDLE});
    check("reset_dpin", {16'd0, datapath_in}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD interrupted by reset while in ALU
    issue(16'hA148, 1'b0);
    step("rst_add_dec",  NONE);
    step("rst_add_geta", pk(0,0,0,1,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00));
    step("rst_add_getb", pk(0,0,0,0,1,0,0,0,0,3'd0,3'd0,2'b00,2'b00));
    check("rst_add_alu", {13'd0, ctl}, {13'd0, pk(0,0,0,0,0,1,0,0,0,3'd0,3'd0,2'b01,2'b00)});
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_abort_ctl", {13'd0, ctl}, {13'd0, IDLE});
    check("rst_abort_dpin", {16'd0, datapath_in}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_write", {13'd0, ctl}, {13'd0, IDLE});
    end

    // MOV R0,#7
    issue(16'hD007, 1'b0);
    in = 16'h1234;
    step("movi7_dec", NONE);
    check("movi7_dpin", {16'd0, datapath_in}, 32'h0007);
    step("movi7_wr", pk(0,1,1,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00));
    step("movi7_wait", IDLE);

    // MOV R1,#-2
    issue(16'hD1FE, 1'b0);
    step("movin_dec", NONE);
    check("movin_dpin", {16'd0, datapath_in}, 32'hFFFE);
    step("movin_wr", pk(0,1,1,0,0,0,0,0,0,3'd0,3'd1,2'b00,2'b00));
    step("movin_wait", IDLE);

    // ADD R2,R1,R0,LSL#1
    issue(16'hA148, 1'b0);
    step("add_dec",  NONE);
    step("add_geta", pk(0,0,0,1,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00));
    step("add_getb", pk(0,0,0,0,1,0,0,0,0,3'd0,3'd0,2'b00,2'b00));
    step("add_alu",  pk(0,0,0,0,0,1,0,0,0,3'd0,3'd0,2'b01,2'b00));
    step("add_wr",   pk(0,1,0,0,0,0,0,0,0,3'd0,3'd2,2'b00,2'b00));
    step("add_wait", IDLE);

    // CMP R1,R0 with s held high, then MVN R3,R2,LSR#1 back-to-back
    issue(16'hA900, 1'b1);
    in = 16'hB872;
    step("cmp_dec",  NONE);
    check("cmp_dpin_hold", {16'd0, datapath_in}, 32'h0000);
    step("cmp_geta", pk(0,0,0,1,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00));
    step("cmp_getb", pk(0,0,0,0,1,0,0,0,0,3'd0,3'd0,2'b00,2'b00));
    step("cmp_alu",  pk(0,0,0,0,0,1,1,0,0,3'd0,3'd0,2'b00,2'b01));
    step("cmp_wait", IDLE);
    s = 1'b0;
    step("mvn_dec",  NONE);
    check("mvn_dpin", {16'd0, datapath_in}, 32'h0072);
    step("mvn_getb", pk(0,0,0,0,1,0,0,0,0,3'd2,3'd0,2'b00,2'b00));
    step("mvn_alu",  pk(0,0,0,0,0,1,0,1,0,3'd0,3'd0,2'b10,2'b11));
    step("mvn_wr",   pk(0,1,0,0,0,0,0,0,0,3'd0,3'd3,2'b00,2'b00));
    step("mvn_wait", IDLE);

    // MOV R5,R4,ASR
    issue(16'hC0BC, 1'b0);
    step("movr_dec",  NONE);
    step("movr_getb", pk(0,0,0,0,1,0,0,0,0,3'd4,3'd0,2'b00,2'b00));
    step("movr_alu",  pk(0,0,0,0,0,1,0,1,0,3'd0,3'd0,2'b11,2'b00));
    step("movr_wr",   pk(0,1,0,0,0,0,0,0,0,3'd0,3'd5,2'b00,2'b00));
    step("movr_wait", IDLE);

    // AND R1,R2,R3
    issue(16'hB223, 1'b0);
    step("and_dec",  NONE);
    step("and_geta", pk(0,0,0,1,0,0,0,0,0,3'd2,3'd0,2'b00,2'b00));
    step("and_getb", pk(0,0,0,0,1,0,0,0,0,3'd3,3'd0,2'b00,2'b00));
    step("and_alu",  pk(0,0,0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b10));
    step("and_wr",   pk(0,1,0,0,0,0,0,0,0,3'd0,3'd1,2'b00,2'b00));
    step("and_wait", IDLE);

    // Illegal opcode
    issue(16'hE000, 1'b0);
    step("ill_dec", NONE);
`ifdef DP_CTRL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      s = i[0];
      check("trap_ctl", {13'd0, ctl}, {13'd0, NONE});
      check("trap_err", {31'd0, err}, 32'd1);
      @(posedge clk);
      #1;
    end
    s = 1'b0;
    reset_n = 1'b0;
    #1;
    check("trap_rst_err", {31'd0, err}, 32'd0);
    check("trap_rst_ctl", {13'd0, ctl}, {13'd0, IDLE});
    @(negedge clk);
    reset_n = 1'b1;
`else
    step("ill_wait", IDLE);
    check("ill_err", {31'd0, err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
